// File: rtl/command_fetch.sv
// Command sequencer: holds the program counter, reads program memory with a
// one-cycle read latency and presents one command at a time over valid/ready.
module command_fetch #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0,
  parameter logic [15:0]       HALT_OPCODE = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [15:0]       mem_data,
  output logic [15:0]       command,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  // state    | meaning
  // S_IDLE   | waiting for run
  // S_ISSUE  | read strobe high, mem_addr = pc
  // S_WAIT   | read data arrives, decoded at cycle end
  // S_PRESENT| command valid, waiting for cmd_ready
  // S_HALT   | halt word fetched, absorbing until reset
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [15:0]       command_q, command_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              halted_q, halted_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    mem_rd_d    = 1'b0;
    command_d   = command_q;
    cmd_valid_d = cmd_valid_q;
    halted_d    = halted_q;

    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d  = S_ISSUE;
          mem_rd_d = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_data == HALT_OPCODE) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          command_d   = mem_data;
          cmd_valid_d = 1'b1;
          state_d     = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (cmd_ready) begin
          pc_d        = jump ? jump_addr : pc_q + ADDR_W'(1);
          mem_addr_d  = pc_d;
          cmd_valid_d = 1'b0;
          if (run) begin
            state_d  = S_ISSUE;
            mem_rd_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= START_ADDR;
      mem_addr_q  <= START_ADDR;
      mem_rd_q    <= 1'b0;
      command_q   <= 16'h0000;
      cmd_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_rd_q    <= mem_rd_d;
      command_q   <= command_d;
      cmd_valid_q <= cmd_valid_d;
      halted_q    <= halted_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = mem_rd_q;
  assign command   = command_q;
  assign cmd_valid = cmd_valid_q;
  assign pc        = pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_command_fetch.sv
// Bench for command_fetch: table of fetch/handshake vectors with a command
// scoreboard, plus hand-written halt and async-reset sequences.
module tb_command_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data = 16'h0000;
  logic [15:0] command;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        jump = 1'b0;
  logic [7:0]  jump_addr = 8'h00;
  logic [7:0]  pc;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] rom [0:255];

  typedef struct {
    logic [15:0] cmd;
    logic [7:0]  pc;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int          stall;
    logic        run_hs;
    logic        jmp;
    logic [7:0]  jaddr;
    logic [15:0] exp_cmd;
    logic [7:0]  exp_pc;
  } vec_t;

  command_fetch #(
    .ADDR_W(8),
    .START_ADDR(8'h00),
    .HALT_OPCODE(16'hFFFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_data(mem_data),
    .command(command),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .jump(jump),
    .jump_addr(jump_addr),
    .pc(pc),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous program memory, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= rom[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_cmd", 32'(command), 32'hDEAD_0000);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_command", 32'(command), 32'(e.cmd));
        check("sb_pc", 32'(pc), 32'(e.pc));
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_pc"}, 32'(pc), 32'h00);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'h00);
    check({tag, "_mem_rd"}, 32'(mem_rd), 32'h0);
    check({tag, "_command"}, 32'(command), 32'h0000);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'h0);
    check({tag, "_halted"}, 32'(halted), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run = 1'b0;
    cmd_ready = 1'b0;
    jump = 1'b0;
    jump_addr = 8'h00;
    sb_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v, input int exp_lat);
    int waits;
    int rd_cnt;
    logic [7:0] nxt;
    sb_t e;
    e.cmd = v.exp_cmd;
    e.pc  = v.exp_pc;
    sb_q.push_back(e);
    run = 1'b1;
    cmd_ready = 1'b0;
    jump = 1'b0;
    waits = 0;
    rd_cnt = mem_rd ? 1 : 0;
    while (!cmd_valid && waits < 20) begin
      @(posedge clk);
      #1;
      waits++;
      if (mem_rd) rd_cnt++;
    end
    check("fetch_latency", 32'(waits), 32'(exp_lat));
    check("mem_rd_pulses", 32'(rd_cnt), 32'd1);
    for (int i = 0; i < v.stall; i++) begin
      run = v.run_hs;
      jump = 1'b1;
      jump_addr = 8'hAA;
      @(posedge clk);
      #1;
      check("stall_command", 32'(command), 32'(v.exp_cmd));
      check("stall_valid", 32'(cmd_valid), 32'h1);
      check("stall_mem_rd", 32'(mem_rd), 32'h0);
      check("stall_pc", 32'(pc), 32'(v.exp_pc));
    end
    run = v.run_hs;
    cmd_ready = 1'b1;
    jump = v.jmp;
    jump_addr = v.jaddr;
    @(posedge clk);
    #1;
    cmd_ready = 1'b0;
    jump = 1'b0;
    nxt = v.jmp ? v.jaddr : 8'(v.exp_pc + 8'd1);
    check("hs_pc", 32'(pc), 32'(nxt));
    check("hs_mem_addr", 32'(mem_addr), 32'(nxt));
    check("hs_valid_drop", 32'(cmd_valid), 32'h0);
    check("hs_cmd_kept", 32'(command), 32'(v.exp_cmd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int lat;
    int n;
    sb_t e;

    for (int i = 0; i < 256; i++) rom[i] = 16'h5000 + 16'(i);
    rom[8'h00] = 16'h1111;
    rom[8'h01] = 16'h2222;
    rom[8'h02] = 16'h3333;
    rom[8'h03] = 16'h4444;
    rom[8'h40] = 16'h4040;
    rom[8'hFF] = 16'hF0FF;

    //          stall run jmp jaddr  cmd       pc
    vecs[0] = '{0,  1'b1, 1'b0, 8'h00, 16'h1111, 8'h00};
    vecs[1] = '{10, 1'b1, 1'b0, 8'h00, 16'h2222, 8'h01};
    vecs[2] = '{0,  1'b1, 1'b1, 8'h40, 16'h3333, 8'h02};
    vecs[3] = '{3,  1'b0, 1'b1, 8'hFF, 16'h4040, 8'h40};
    vecs[4] = '{0,  1'b1, 1'b0, 8'h00, 16'hF0FF, 8'hFF};
    vecs[5] = '{1,  1'b1, 1'b0, 8'h00, 16'h1111, 8'h00};
    vecs[6] = '{0,  1'b1, 1'b1, 8'h41, 16'h2222, 8'h01};
    vecs[7] = '{0,  1'b1, 1'b0, 8'h00, 16'h5041, 8'h41};

    // Reset state, then idle with run low.
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    do_reset();
    check_reset("post_reset");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("idle_mem_rd", 32'(mem_rd), 32'h0);
      check("idle_valid", 32'(cmd_valid), 32'h0);
    end

    for (int i = 0; i < 8; i++) begin
      lat = (i == 0) ? 3 : (vecs[i-1].run_hs ? 2 : 3);
      apply(vecs[i], lat);
    end
    check("table_sb_empty", 32'(sb_q.size()), 32'd0);

    // Halt word at address 3.
    do_reset();
    rom[8'h03] = 16'hFFFF;
    e.cmd = 16'h1111; e.pc = 8'h00; sb_q.push_back(e);
    e.cmd = 16'h2222; e.pc = 8'h01; sb_q.push_back(e);
    e.cmd = 16'h3333; e.pc = 8'h02; sb_q.push_back(e);
    run = 1'b1;
    cmd_ready = 1'b1;
    n = 0;
    while (!halted && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("halt_reached", 32'(halted), 32'h1);
    check("halt_pc", 32'(pc), 32'h03);
    check("halt_valid", 32'(cmd_valid), 32'h0);
    check("halt_command", 32'(command), 32'h3333);
    check("halt_sb_empty", 32'(sb_q.size()), 32'd0);
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1));
      cmd_ready = 1'($urandom_range(0, 1));
      jump = 1'($urandom_range(0, 1));
      jump_addr = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      check("halt_hold_valid", 32'(cmd_valid), 32'h0);
      check("halt_hold_pc", 32'(pc), 32'h03);
      check("halt_hold_halted", 32'(halted), 32'h1);
      check("halt_hold_mem_rd", 32'(mem_rd), 32'h0);
    end
    rom[8'h03] = 16'h4444;

    // Async reset during WAIT, then during PRESENT.
    do_reset();
    e.cmd = 16'h1111; e.pc = 8'h00; sb_q.push_back(e);
    e.cmd = 16'h2222; e.pc = 8'h01; sb_q.push_back(e);
    run = 1'b1;
    cmd_ready = 1'b1;
    n = 0;
    while (pc !== 8'h02 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    cmd_ready = 1'b0;
    check("rst_pre_pc", 32'(pc), 32'h02);
    check("rst_pre_issue", 32'(mem_rd), 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_in_wait");
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!cmd_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("restart_latency", 32'(n), 32'd3);
    check("restart_command", 32'(command), 32'h1111);
    check("restart_pc", 32'(pc), 32'h00);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset("rst_in_present");
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b0;
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
